// File: rtl/aes_key_schedule.sv
// AES key-expansion engine for AES-128/192/256.
// Expands the cipher key into the word schedule at one word per clock and
// serves 128-bit round keys through a registered read port.

// AES forward S-box, one byte in, one byte out, purely combinational.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y_o = SBOX[a_i];
endmodule

module aes_key_schedule #(
    parameter int MAX_NK = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             key_len,
    input  logic [32*MAX_NK-1:0]   init_key,
    input  logic                   rk_rd_en,
    input  logic [3:0]             rk_round,
    output logic [127:0]           rk_data,
    output logic                   rk_valid,
    output logic                   rk_err,
    output logic                   busy,
    output logic                   done,
    output logic                   keys_valid,
    output logic [3:0]             nr,
    output logic                   cfg_err
);
    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [3:0]     nk_q, nk_d;
    logic [3:0]     nr_q, nr_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [2:0]     mod_q, mod_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           keys_valid_q, keys_valid_d;
    logic           cfg_err_q, cfg_err_d;
    logic           load_en, gen_en;

    logic [127:0]   rk_data_q;
    logic           rk_valid_q, rk_err_q;

    logic [31:0]    mem [DEPTH];

    // Key-length decode of the start request.
    logic [3:0]     req_nk;
    logic           req_ok;

    // Datapath for the word being generated.
    logic [31:0]    prev_w, back_w, rot_w, sub_in, sub_out, t_w, new_w;
    logic [AW-1:0]  last_idx;
    logic [7:0]     rcon_next;

    // Decode key_len into Nk and flag illegal or oversized requests.
    always_comb begin
        req_nk = 4'd0;
        case (key_len)
            2'b00:   req_nk = 4'd4;
            2'b01:   req_nk = 4'd6;
            2'b10:   req_nk = 4'd8;
            default: req_nk = 4'd0;
        endcase
        req_ok = (key_len != 2'b11) && (int'(req_nk) <= MAX_NK);
    end

    assign prev_w    = mem[idx_q - AW'(1)];
    assign back_w    = mem[idx_q - AW'(nk_q)];
    assign rot_w     = {prev_w[23:0], prev_w[31:24]};
    assign sub_in    = (mod_q == 3'd0) ? rot_w : prev_w;
    assign last_idx  = AW'({nr_q, 2'b11});
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (sub_in[8*g +: 8]),
            .y_o (sub_out[8*g +: 8])
        );
    end

    // Select the mixing term t for word i from its position within the key period.
    always_comb begin
        t_w = prev_w;
        if (mod_q == 3'd0) begin
            t_w = sub_out ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
            t_w = sub_out;
        end
        new_w = back_w ^ t_w;
    end

    // FSM next-state and control decode.
    // NOTE: every signal driven here gets a default first so no path can leave it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d      = state_q;
        nk_d         = nk_q;
        nr_d         = nr_q;
        idx_d        = idx_q;
        mod_d        = mod_q;
        rcon_d       = rcon_q;
        keys_valid_d = keys_valid_q;
        cfg_err_d    = 1'b0;
        load_en      = 1'b0;
        gen_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        nk_d         = req_nk;
                        nr_d         = req_nk + 4'd6;
                        keys_valid_d = 1'b0;
                        state_d      = S_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                idx_d   = AW'(nk_q);
                mod_d   = 3'd0;
                rcon_d  = 8'h01;
                state_d = S_GEN;
            end
            S_GEN: begin
                gen_en = 1'b1;
                idx_d  = idx_q + AW'(1);
                mod_d  = (4'(mod_q) + 4'd1 == nk_q) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0) begin
                    rcon_d = rcon_next;
                end
                if (idx_q == last_idx) begin
                    keys_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register.
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            nk_q         <= 4'd0;
            nr_q         <= 4'd0;
            idx_q        <= '0;
            mod_q        <= 3'd0;
            rcon_q       <= 8'h00;
            keys_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            nk_q         <= nk_d;
            nr_q         <= nr_d;
            idx_q        <= idx_d;
            mod_q        <= mod_d;
            rcon_q       <= rcon_d;
            keys_valid_q <= keys_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Word storage: cipher key words on LOAD, one expanded word per GEN cycle.
    // NOTE: the schedule storage has no reset; contents are only trusted while
    // keys_valid is high, and leaving it unreset lets it map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        for (int j = 0; j < MAX_NK; j++) begin
            if (load_en && (j < int'(nk_q))) begin
                mem[AW'(j)] <= init_key[32*(MAX_NK-j)-1 -: 32];
            end
        end
        if (gen_en) begin
            mem[idx_q] <= new_w;
        end
    end

    logic [AW-1:0] rd_base;
    logic          rd_ok;
    assign rd_base = AW'({rk_round, 2'b00});
    assign rd_ok   = keys_valid_q && (rk_round <= nr_q);

    // Registered round-key read port; out-of-range or pre-expansion reads return zero with rk_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_data_q  <= '0;
        end else begin
            rk_valid_q <= rk_rd_en;
            if (rk_rd_en) begin
                if (rd_ok) begin
                    rk_data_q <= {mem[rd_base], mem[rd_base + AW'(1)],
                                  mem[rd_base + AW'(2)], mem[rd_base + AW'(3)]};
                    rk_err_q  <= 1'b0;
                end else begin
                    rk_data_q <= '0;
                    rk_err_q  <= 1'b1;
                end
            end
        end
    end

    assign rk_data    = rk_data_q;
    assign rk_valid   = rk_valid_q;
    assign rk_err     = rk_err_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_GEN);
    assign done       = (state_q == S_DONE);
    assign keys_valid = keys_valid_q;
    assign nr         = keys_valid_q ? nr_q : 4'd0;
    assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed self-checking bench for aes_key_schedule using FIPS-197 key vectors.
module tb_aes_key_schedule;
    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     key_len = 2'b00;
    logic [255:0]   init_key = '0;
    logic           rk_rd_en = 1'b0;
    logic [3:0]     rk_round = 4'd0;
    logic [127:0]   rk_data;
    logic           rk_valid, rk_err, busy, done, keys_valid, cfg_err;
    logic [3:0]     nr;

    // Second instance limited to AES-128 keys.
    logic           start4 = 1'b0;
    logic [1:0]     key_len4 = 2'b00;
    logic [127:0]   init_key4 = '0;
    logic [127:0]   rk_data4;
    logic           rk_valid4, rk_err4, busy4, done4, keys_valid4, cfg_err4;
    logic [3:0]     nr4;

    int tests_run = 0;
    int fails = 0;

    localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K128_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] K192_R1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] K192_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] K256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes_key_schedule #(.MAX_NK(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_len    (key_len),
        .init_key   (init_key),
        .rk_rd_en   (rk_rd_en),
        .rk_round   (rk_round),
        .rk_data    (rk_data),
        .rk_valid   (rk_valid),
        .rk_err     (rk_err),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .nr         (nr),
        .cfg_err    (cfg_err)
    );

    aes_key_schedule #(.MAX_NK(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start4),
        .key_len    (key_len4),
        .init_key   (init_key4),
        .rk_rd_en   (1'b0),
        .rk_round   (4'd0),
        .rk_data    (rk_data4),
        .rk_valid   (rk_valid4),
        .rk_err     (rk_err4),
        .busy       (busy4),
        .done       (done4),
        .keys_valid (keys_valid4),
        .nr         (nr4),
        .cfg_err    (cfg_err4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read and check the response one cycle later.
    task automatic do_read(input string tag, input logic [3:0] r,
                           input logic [127:0] exp_data, input logic exp_err);
        rk_rd_en = 1'b1;
        rk_round = r;
        tick();
        rk_rd_en = 1'b0;
        chk({tag, "_valid"}, 128'(rk_valid), 128'(1'b1));
        chk({tag, "_err"},   128'(rk_err),   128'(exp_err));
        chk({tag, "_data"},  rk_data,        exp_data);
    endtask

    // Present start for one edge (E0).
    task automatic kick(input logic [1:0] len, input logic [255:0] key);
        key_len  = len;
        init_key = key;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Count edges after E0 until done is seen; 0 means it never came.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int  n;
        bit  pre_ok;

        // Reset state.
        #3;
        chk("rst_busy",       128'(busy),       128'(1'b0));
        chk("rst_done",       128'(done),       128'(1'b0));
        chk("rst_keys_valid", 128'(keys_valid), 128'(1'b0));
        chk("rst_nr",         128'(nr),         128'(4'd0));
        chk("rst_rk_valid",   128'(rk_valid),   128'(1'b0));
        chk("rst_rk_data",    rk_data,          128'h0);
        chk("rst_cfg_err",    128'(cfg_err),    128'(1'b0));
        tick();
        reset = 1'b1;
        tick();

        // Read before any expansion.
        do_read("pre_rd", 4'd0, 128'h0, 1'b1);
        tick();
        chk("pre_rd_valid_drop", 128'(rk_valid), 128'(1'b0));

        // Illegal key length with no keys loaded.
        kick(2'b11, K256);
        chk("ill_cfg_err",  128'(cfg_err),    128'(1'b1));
        chk("ill_busy",     128'(busy),       128'(1'b0));
        tick();
        chk("ill_cfg_pulse", 128'(cfg_err),   128'(1'b0));
        chk("ill_kv",        128'(keys_valid), 128'(1'b0));

        // AES-128 with a read of round 10 every cycle and a stray start during GEN.
        rk_rd_en = 1'b1;
        rk_round = 4'd10;
        kick(2'b00, {K128, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff});
        pre_ok = 1'b1;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                n = k;
                break;
            end
            if (!(rk_valid === 1'b1 && rk_err === 1'b1 && rk_data === 128'h0)) pre_ok = 1'b0;
            if (k == 20) begin
                chk("a128_busy_gen", 128'(busy), 128'(1'b1));
                key_len = 2'b01;
                start   = 1'b1;
            end
        end
        chk("a128_done_edge",   128'(n),          128'(41));
        chk("a128_reads_pre",   128'(pre_ok),     128'(1'b1));
        chk("a128_kv",          128'(keys_valid), 128'(1'b1));
        chk("a128_nr",          128'(nr),         128'(4'd10));
        chk("a128_busy_done",   128'(busy),       128'(1'b0));
        chk("a128_err_at_done", 128'(rk_err),     128'(1'b1));
        tick();
        chk("a128_done_pulse",  128'(done),       128'(1'b0));
        chk("a128_rd_valid",    128'(rk_valid),   128'(1'b1));
        chk("a128_rd_err",      128'(rk_err),     128'(1'b0));
        chk("a128_rd_r10",      rk_data,          K128_R10);
        rk_rd_en = 1'b0;
        tick();
        chk("a128_rd_drop",     128'(rk_valid),   128'(1'b0));
        do_read("a128_r0",  4'd0,  K128,    1'b0);
        do_read("a128_r1",  4'd1,  K128_R1, 1'b0);
        do_read("a128_r11", 4'd11, 128'h0,  1'b1);

        // Illegal request with keys held: keys_valid and nr must survive.
        kick(2'b11, K256);
        chk("ill2_cfg_err", 128'(cfg_err),    128'(1'b1));
        chk("ill2_busy",    128'(busy),       128'(1'b0));
        chk("ill2_kv",      128'(keys_valid), 128'(1'b1));
        chk("ill2_nr",      128'(nr),         128'(4'd10));

        // AES-192 started together with a read: the read sees the old schedule.
        rk_rd_en = 1'b1;
        rk_round = 4'd10;
        kick(2'b01, {K192, 64'h0123_4567_89ab_cdef});
        rk_rd_en = 1'b0;
        chk("a192_simrd_err",  128'(rk_err),     128'(1'b0));
        chk("a192_simrd_data", rk_data,          K128_R10);
        chk("a192_kv_clr",     128'(keys_valid), 128'(1'b0));
        chk("a192_nr_clr",     128'(nr),         128'(4'd0));
        chk("a192_busy",       128'(busy),       128'(1'b1));
        wait_done(n);
        chk("a192_done_edge",  128'(n),          128'(47));
        chk("a192_nr",         128'(nr),         128'(4'd12));
        do_read("a192_r0",  4'd0,  K192_R0,  1'b0);
        do_read("a192_r1",  4'd1,  K192_R1,  1'b0);
        do_read("a192_r12", 4'd12, K192_R12, 1'b0);
        do_read("a192_r13", 4'd13, 128'h0,   1'b1);

        // AES-256.
        kick(2'b10, K256);
        wait_done(n);
        chk("a256_done_edge", 128'(n),  128'(53));
        chk("a256_nr",        128'(nr), 128'(4'd14));
        do_read("a256_r1",  4'd1,  K256_R1,  1'b0);
        do_read("a256_r3",  4'd3,  K256_R3,  1'b0);
        do_read("a256_r14", 4'd14, K256_R14, 1'b0);
        do_read("a256_r15", 4'd15, 128'h0,   1'b1);

        // MAX_NK=4 instance: run AES-128, then reject AES-256.
        key_len4  = 2'b00;
        init_key4 = K128;
        start4    = 1'b1;
        tick();
        start4    = 1'b0;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done4 === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("nk4_done_edge", 128'(n),   128'(41));
        chk("nk4_nr",        128'(nr4), 128'(4'd10));
        tick();
        key_len4 = 2'b10;
        start4   = 1'b1;
        tick();
        start4   = 1'b0;
        chk("nk4_cfg_err", 128'(cfg_err4),    128'(1'b1));
        chk("nk4_busy",    128'(busy4),       128'(1'b0));
        chk("nk4_kv",      128'(keys_valid4), 128'(1'b1));
        chk("nk4_nr_keep", 128'(nr4),         128'(4'd10));
        tick();
        chk("nk4_cfg_pulse", 128'(cfg_err4), 128'(1'b0));

        // Reset in the middle of GEN, then a fresh AES-128 run.
        kick(2'b00, {K128, 128'h0});
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) rk_rd_en = 1'b1;
            tick();
        end
        rk_rd_en = 1'b0;
        chk("mid_busy_pre", 128'(busy),     128'(1'b1));
        chk("mid_rdv_pre",  128'(rk_valid), 128'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy",  128'(busy),       128'(1'b0));
        chk("mid_rst_done",  128'(done),       128'(1'b0));
        chk("mid_rst_kv",    128'(keys_valid), 128'(1'b0));
        chk("mid_rst_rdv",   128'(rk_valid),   128'(1'b0));
        chk("mid_rst_nr",    128'(nr),         128'(4'd0));
        tick();
        reset = 1'b1;
        tick();
        kick(2'b00, {K128, 128'h0});
        wait_done(n);
        chk("re128_done_edge", 128'(n), 128'(41));
        do_read("re128_r10", 4'd10, K128_R10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised AES key-expansion engine (FIPS-197 §5.2) supporting AES-128/192/256, with the key length selected per run at `start`. It expands the cipher key into the full word schedule at one word per clock. It then serves round keys to the cipher datapath through a registered read port. The block sits between the key-load interface and the `add_round_key` stage, and replaces the fixed 128-bit expander.

## Interface
- `MAX_NK`, default 8: largest supported key length in 32-bit words; legal values are 4, 6, 8. Storage is `4*(MAX_NK+7)` words.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all control state immediately.
- `start` input 1: request expansion; sampled only in IDLE.
- `key_len` input 2: `00`=128, `01`=192, `10`=256, `11`=illegal; sampled with `start`.
- `init_key` input `32*MAX_NK`: cipher key, left-aligned; w[0] = `init_key[32*MAX_NK-1 -: 32]`; unused LSBs are ignored.
- `rk_rd_en` input 1: round-key read request.
- `rk_round` input 4: round number to read (0..Nr).
- `rk_data` output 128: `{w[4r], w[4r+1], w[4r+2], w[4r+3]}`, registered.
- `rk_valid` output 1: one-cycle pulse, asserted the cycle after `rk_rd_en`.
- `rk_err` output 1: qualifies `rk_valid`; the read was out of range or no keys were valid.
- `busy` output 1: high in LOAD and GEN.
- `done` output 1: one-cycle pulse when the schedule is complete.
- `keys_valid` output 1: high from `done` until the next accepted `start` or reset.
- `nr` output 4: Nr of the current schedule (10/12/14); 0 when `keys_valid`=0.
- `cfg_err` output 1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, LOAD, GEN, DONE. Reset forces IDLE. All outputs reset to 0, and the word storage is not reset.
- IDLE: on `start`=1, the block checks `key_len`.
  - If `key_len`=`11`, or the implied Nk > `MAX_NK`, it pulses `cfg_err` and stays in IDLE. `keys_valid` is unchanged.
  - Otherwise it latches Nk (4/6/8) and Nr = Nk+6, clears `keys_valid`, and goes to LOAD.
- LOAD (1 cycle): writes w[0..Nk-1] from `init_key`, sets i = Nk and the rcon register to 0x01, then goes to GEN.
- GEN: writes one word per cycle, w[i] = w[i-Nk] ^ t, where t is selected as follows:
  - If i mod Nk = 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}. rcon then updates to xtime(rcon), i.e. shift left with conditional XOR of 0x1b, 8-bit.
  - Else if Nk = 8 and i mod 8 = 4: t = SubWord(w[i-1]), with no rotation and no rcon.
  - Else: t = w[i-1].
- RotWord([a0,a1,a2,a3]) = [a1,a2,a3,a0]. SubWord uses 4 parallel `sbox` instances.
- i mod Nk is tracked by a wrapping counter (0..Nk-1), not a divider.
- When the word i = 4*Nr+3 is written, the block goes to DONE. DONE lasts 1 cycle: `done`=1, `keys_valid` is set, then the block returns to IDLE.
- Read port, evaluated every cycle in any state:
  - If `rk_rd_en`=1, then on the next cycle `rk_valid`=1.
  - If `keys_valid`=1 and `rk_round` ≤ Nr: `rk_data` = round key and `rk_err`=0.
  - Otherwise: `rk_data` = 0 and `rk_err`=1.
- `start` while `busy` or in DONE is ignored, with no `cfg_err`.

## Timing
- Let `start` be sampled at edge E0. LOAD follows E0, GEN follows E1, and the G generated words are written at E2..E(G+1).
- G = 4*Nr+4-Nk: 40 for AES-128, 46 for AES-192, 52 for AES-256.
- `done` and `keys_valid` rise after E(G+1): edge 41 for 128, 47 for 192, 53 for 256.
- A read issued in the same cycle as `done` already returns valid data.
- Read latency is exactly 1 cycle. Back-to-back reads every cycle are supported.
- Reset asserted mid-GEN: the block returns to IDLE asynchronously with `busy`, `done`, `keys_valid` and `rk_valid` at 0. The next `start` restarts from LOAD.
- Simultaneous `rk_rd_en` and `start` in IDLE: the read sees the pre-start `keys_valid`, and the expansion proceeds normally.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, `start` at E0 -> `done` after E41; read round 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6; read round 0 returns the key.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> `done` after E47, `nr`=12; round 12 returns e98ba06f448c773c8ecc720401002202; round 13 returns `rk_err`=1 with data 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> `done` after E53; round 14 returns fe4890d1e6188d0b046df344706c631e, which checks the i mod 8 = 4 SubWord path.
- `key_len`=`11` at `start`, or 256 with `MAX_NK`=4 -> one-cycle `cfg_err`, `busy` stays 0, prior `keys_valid`/`nr` unchanged.
- Reset pulsed at GEN cycle 20, then AES-128 restart -> all outputs 0 during reset; correct round 10 key after a fresh 41-edge run; `start` pulses during GEN are ignored.
- Read before any expansion, and reads every cycle across `done` -> `rk_err`=1 before `done`, valid keys from the `done` cycle onward, `rk_valid` one cycle after each request.
